dotmatrix_sequencer: RTL and testbench
======================================

// Module: dotmatrix_sequencer
// PURPOSE
//  Message controller for the 16x16 LED dot-matrix panel. Steps through a programmable list of
//  glyph indices with a fixed dwell time. Fetches each glyph's 16 row words from the shared glyph ROM
//  into a back buffer, then swaps it to the front buffer only at a scan-frame boundary (no tearing).
//  Drives the row scan (selout/dotout) continuously. Sits between the CPU/config side and the panel pins.
// PARAMETERS
//  DWELL_CYC  500  clk cycles each glyph is shown; legal range 40..4095
//  GLYPH_AW   6    glyph index width (64 glyphs in ROM)
//  MSG_DEPTH  16   message slots (fixed at 16; slot address 4 bits)
// PORTS
//  clk        in   1           system clock, single domain
//  rst        in   1           synchronous, active-high reset
//  run        in   1           1: dwell counter advances; 0: dwell holds, scan continues
//  msg_we     in   1           write strobe for message slot
//  msg_waddr  in   4           slot written
//  msg_wdata  in   GLYPH_AW    glyph index stored in slot
//  msg_len    in   5           active slots 0..16; 0 = blank panel
//  rom_addr   out  GLYPH_AW+4  {glyph, row} to glyph ROM
//  rom_data   in   16          row word; valid exactly 1 clk after rom_addr (registered ROM)
//  selout     out  4           row select to panel
//  dotout     out  16          column data for row selout
//  char_idx   out  4           slot currently on display
//  busy       out  1           load FSM not IDLE
// BEHAVIOUR
//  Reset: selout=0, dotout=0, char_idx=0, busy=0, rom_addr=0, dwell=0, front and back buffers all 0.
//   Msg RAM not cleared. In the first cycle after rst falls, the FSM enters LOAD for slot 0.
//  Scan: every clk, selout <= selout+1 (wraps 15->0). dotout <= front[next selout], registered with selout
//   (dotout always equals the front row addressed by the current selout). Scan never stalls, including while run=0.
//  Dwell: when run=1, count 0..DWELL_CYC-1. At terminal count: count<=0, next_slot = (slot+1 >= msg_len) ? 0 : slot+1,
//   and the FSM starts LOAD. msg_len is sampled only here and at reset exit.
//  Load FSM: IDLE -> FETCH -> DRAIN -> WAIT_EDGE -> IDLE.
//   FETCH entry: latch glyph index from the msg RAM slot; issue rom_addr rows 0..15 on 16 consecutive cycles.
//   Row r data is written to back[r] on the next cycle. DRAIN captures row 15.
//   WAIT_EDGE: hold until selout==15. On that cycle, front<=back (the 16 words transfer atomically) and char_idx<=slot.
//   The next frame (selout==0) shows the new glyph. Worst-case load-to-visible latency is 34 clk.
//   msg_len==0: no ROM access; back<=0 in FETCH's first cycle, go straight to WAIT_EDGE; char_idx=0.
//  Boundaries:
//   msg_len > 16 is treated as 16.
//   If msg_len shrinks below slot+1, the next advance wraps to slot 0.
//   A msg_we to the slot being fetched takes effect at its next display; the latched index is not altered.
//   Simultaneous msg_we and fetch read of the same slot: the read returns the old value.
//   A dwell terminal while busy cannot occur when DWELL_CYC>=40. If it does, the request is dropped and the dwell restarts.
//   run=0 mid-LOAD: the load completes. Only the dwell count freezes.
//   rst mid-LOAD: abort immediately. All reset values apply, including a blank panel on the next cycle.
// STRUCTURE
//  Package dotmatrix_pkg: ROWS=16, COLS=16, ROW_W=4, GLYPH_AW default, load-FSM state encoding.
//  Sub-module dotmatrix_framebuf: front/back 16x16 registers, back write port (row, data, we),
//   swap strobe, front read by row. The top holds the msg RAM, dwell counter, slot logic, FSM and scan counter.
// TESTING
//  Reset then idle, msg_len=0 -> dotout==0 every cycle, selout counts 0..15 repeating, busy pulses once (<=34 clk).
//  Program slots 0..2 = glyphs 5,9,1, msg_len=3, run=1, DWELL_CYC=40 -> char_idx sequence 0,1,2,0.
//   rom_addr = {5,0..15} then {9,0..15}. Each swap occurs at selout 15->0.
//  Scoreboard: for every cycle, dotout == model_ROM[glyph(char_idx)][selout] after the first swap; zero torn frames.
//  run=0 for 300 clk mid-dwell -> char_idx frozen, scan continues. Resumes with the remaining dwell count exactly.
//  Rewrite slot 1 with 7 while slot 1 is fetching -> current display is glyph 9, next pass of slot 1 shows glyph 7.
//  Assert rst at FETCH row 8 -> next cycle dotout=0, selout=0, busy=0. Fresh load of slot 0 follows; ROM rows restart at 0.

Source files
------------

// File: rtl/dotmatrix_pkg.sv
// Shared constants, load-FSM encoding and small helpers for the dot-matrix
// message sequencer.
package dotmatrix_pkg;

    localparam int ROWS             = 16;
    localparam int COLS             = 16;
    localparam int ROW_W            = 4;
    localparam int GLYPH_AW_DEFAULT = 6;
    localparam int DWELL_W          = 12;
    localparam int LEN_W            = 5;

    typedef enum logic [1:0] {
        LOAD_IDLE,
        LOAD_FETCH,
        LOAD_DRAIN,
        LOAD_WAIT_EDGE
    } load_state_t;

    // Message lengths above the slot count behave as a full 16-slot message.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        return (len > LEN_W'(ROWS)) ? LEN_W'(ROWS) : len;
    endfunction

endpackage

// File: rtl/dotmatrix_framebuf.sv
// Front/back 16x16 frame buffers: the back buffer is filled row by row while
// the front buffer is scanned; a single swap strobe copies all rows at once.
module dotmatrix_framebuf
    import dotmatrix_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [ROW_W-1:0] wr_row,
    input  logic [COLS-1:0]  wr_data,
    input  logic             clear,
    input  logic             swap,
    input  logic [ROW_W-1:0] rd_row,
    output logic [COLS-1:0]  rd_data
);

    logic [COLS-1:0] front [ROWS];
    logic [COLS-1:0] back  [ROWS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ROWS; i++) begin
                front[i] <= '0;
                back[i]  <= '0;
            end
        end else begin
            if (clear) begin
                for (int i = 0; i < ROWS; i++) begin
                    back[i] <= '0;
                end
            end else if (wr_en) begin
                back[wr_row] <= wr_data;
            end
            if (swap) begin
                for (int i = 0; i < ROWS; i++) begin
                    front[i] <= back[i];
                end
            end
        end
    end

    // On the swap cycle the scan register must already see the incoming glyph.
    assign rd_data = swap ? back[rd_row] : front[rd_row];

endmodule

// File: rtl/dotmatrix_sequencer.sv
// Message controller for the 16x16 dot-matrix panel: dwell timing, glyph
// fetch from the shared ROM into the back buffer, tear-free swap and row scan.
module dotmatrix_sequencer
    import dotmatrix_pkg::*;
#(
    parameter int DWELL_CYC = 500,
    parameter int GLYPH_AW  = GLYPH_AW_DEFAULT,
    parameter int MSG_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic                  msg_we,
    input  logic [3:0]            msg_waddr,
    input  logic [GLYPH_AW-1:0]   msg_wdata,
    input  logic [4:0]            msg_len,
    output logic [GLYPH_AW+3:0]   rom_addr,
    input  logic [15:0]           rom_data,
    output logic [3:0]            selout,
    output logic [15:0]           dotout,
    output logic [3:0]            char_idx,
    output logic                  busy
);

    load_state_t           state;
    logic [GLYPH_AW-1:0]   msg_ram [MSG_DEPTH];
    logic [DWELL_W-1:0]    dwell;
    logic [ROW_W-1:0]      slot;
    logic [ROW_W-1:0]      row_cnt;
    logic [GLYPH_AW-1:0]   glyph;
    logic                  len_zero;
    logic                  start_pending;
    logic [LEN_W-1:0]      len_now;
    logic [LEN_W-1:0]      slot_inc;
    logic [ROW_W-1:0]      next_slot;
    logic [ROW_W-1:0]      load_slot;
    logic                  dwell_tc;
    logic                  load_req;
    logic                  fb_we;
    logic                  fb_clear;
    logic                  fb_swap;
    logic [ROW_W-1:0]      fb_wrow;
    logic [ROW_W-1:0]      scan_next;
    logic [COLS-1:0]       fb_rdata;

    always_ff @(posedge clk) begin
        if (msg_we) begin
            msg_ram[msg_waddr] <= msg_wdata;
        end
    end

    assign len_now   = clamp_len(msg_len);
    assign slot_inc  = LEN_W'(slot) + LEN_W'(1);
    assign next_slot = (slot_inc >= len_now) ? '0 : slot_inc[ROW_W-1:0];
    assign dwell_tc  = run && (dwell == DWELL_W'(DWELL_CYC - 1));
    // A terminal count arriving while a load is still running is dropped.
    assign load_req  = start_pending || (dwell_tc && state == LOAD_IDLE);
    assign load_slot = start_pending ? '0 : next_slot;

    // ROM data lags the address by one cycle, so row r lands while row r+1 is issued.
    assign fb_we     = (state == LOAD_FETCH && !len_zero && row_cnt != '0) || state == LOAD_DRAIN;
    assign fb_wrow   = (state == LOAD_DRAIN) ? ROW_W'(ROWS - 1) : row_cnt - ROW_W'(1);
    assign fb_clear  = (state == LOAD_FETCH) && len_zero;
    assign fb_swap   = (state == LOAD_WAIT_EDGE) && (selout == ROW_W'(ROWS - 1));
    assign scan_next = selout + ROW_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            dwell <= '0;
        end else if (run) begin
            dwell <= dwell_tc ? '0 : dwell + DWELL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= LOAD_IDLE;
            start_pending <= 1'b1;
            slot          <= '0;
            glyph         <= '0;
            len_zero      <= 1'b0;
            row_cnt       <= '0;
            rom_addr      <= '0;
            char_idx      <= '0;
            busy          <= 1'b0;
        end else begin
            case (state)
                LOAD_IDLE: begin
                    if (load_req) begin
                        start_pending <= 1'b0;
                        slot          <= load_slot;
                        glyph         <= msg_ram[load_slot];
                        len_zero      <= (len_now == '0);
                        row_cnt       <= '0;
                        if (len_now != '0) begin
                            rom_addr <= {msg_ram[load_slot], ROW_W'(0)};
                        end
                        busy          <= 1'b1;
                        state         <= LOAD_FETCH;
                    end
                end
                LOAD_FETCH: begin
                    if (len_zero) begin
                        state <= LOAD_WAIT_EDGE;
                    end else if (row_cnt == ROW_W'(ROWS - 1)) begin
                        state <= LOAD_DRAIN;
                    end else begin
                        row_cnt  <= row_cnt + ROW_W'(1);
                        rom_addr <= {glyph, row_cnt + ROW_W'(1)};
                    end
                end
                LOAD_DRAIN: begin
                    state <= LOAD_WAIT_EDGE;
                end
                LOAD_WAIT_EDGE: begin
                    if (fb_swap) begin
                        char_idx <= slot;
                        busy     <= 1'b0;
                        state    <= LOAD_IDLE;
                    end
                end
                default: begin
                    state <= LOAD_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            selout <= '0;
            dotout <= '0;
        end else begin
            selout <= scan_next;
            dotout <= fb_rdata;
        end
    end

    dotmatrix_framebuf u_framebuf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (fb_we),
        .wr_row  (fb_wrow),
        .wr_data (rom_data),
        .clear   (fb_clear),
        .swap    (fb_swap),
        .rd_row  (scan_next),
        .rd_data (fb_rdata)
    );

endmodule

// File: tb/tb_dotmatrix_sequencer.sv
// Directed bench for dotmatrix_sequencer: a queue of expected glyph loads is
// matched against each load the sequencer performs, and every scanned row is checked.
module tb_dotmatrix_sequencer;

    localparam int DWELL = 40;
    localparam int GAW   = 6;

    typedef struct {
        logic [3:0]     slot;
        logic [GAW-1:0] glyph;
        logic           blank;
        int             gap;
    } load_exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           run = 1'b0;
    logic           msg_we = 1'b0;
    logic [3:0]     msg_waddr = '0;
    logic [GAW-1:0] msg_wdata = '0;
    logic [4:0]     msg_len = '0;
    logic [GAW+3:0] rom_addr;
    logic [15:0]    rom_data = '0;
    logic [3:0]     selout;
    logic [15:0]    dotout;
    logic [3:0]     char_idx;
    logic           busy;

    int        vectors = 0;
    int        miscompares = 0;
    load_exp_t sb[$];

    load_exp_t      cur_load;
    bit             mon_en = 1'b0;
    logic           rst_seen = 1'b1;
    logic [3:0]     exp_sel = '0;
    logic           prev_busy = 1'b0;
    logic           inflight = 1'b0;
    logic           cur_blank = 1'b1;
    logic [3:0]     cur_slot = '0;
    logic [GAW-1:0] cur_glyph = '0;
    int             fetch_row = 16;
    int             busy_len = 0;
    int             cyc = 0;
    int             last_rise = 0;
    int             load_count = 0;
    int             lc0;
    bit             fell;

    dotmatrix_sequencer #(
        .DWELL_CYC (DWELL),
        .GLYPH_AW  (GAW),
        .MSG_DEPTH (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .msg_we    (msg_we),
        .msg_waddr (msg_waddr),
        .msg_wdata (msg_wdata),
        .msg_len   (msg_len),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .selout    (selout),
        .dotout    (dotout),
        .char_idx  (char_idx),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rom_word(input logic [GAW-1:0] g, input logic [3:0] r);
        return {g[3:0] ^ r, 2'b10, g, r};
    endfunction

    always @(posedge clk) begin
        rom_data <= rom_word(rom_addr[GAW+3:4], rom_addr[3:0]);
        rst_seen <= rst;
        exp_sel  <= rst ? 4'd0 : exp_sel + 4'd1;
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_slot(input logic [3:0] a, input logic [GAW-1:0] d);
        msg_waddr = a;
        msg_wdata = d;
        msg_we    = 1'b1;
        @(negedge clk);
        msg_we    = 1'b0;
    endtask

    task automatic wait_load_start(input int budget);
        logic was;
        bit   seen;
        seen = 1'b0;
        was  = busy;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (busy && !was) seen = 1'b1;
            was = busy;
        end
        check_output("load_start_timeout", 32'(seen), 32'd1);
    endtask

    // Pop one expectation per load start, adopt it as the displayed glyph at load end.
    always @(negedge clk) begin
        if (mon_en) begin
            cyc++;
            if (rst_seen) begin
                inflight  = 1'b0;
                cur_blank = 1'b1;
                cur_slot  = '0;
                fetch_row = 16;
            end else begin
                if (busy && !prev_busy) begin
                    load_count++;
                    check_output("sb_pending", 32'(sb.size() != 0), 32'd1);
                    if (sb.size() != 0) begin
                        cur_load = sb.pop_front();
                        inflight = 1'b1;
                        if (cur_load.gap > 0)
                            check_output("dwell_gap", 32'(cyc - last_rise), 32'(cur_load.gap));
                        fetch_row = cur_load.blank ? 16 : 0;
                    end
                    last_rise = cyc;
                    busy_len  = 0;
                end
                if (busy) busy_len++;
                if (fetch_row < 16) begin
                    check_output("rom_addr", 32'(rom_addr), 32'({cur_load.glyph, 4'(fetch_row)}));
                    fetch_row++;
                end
                if (!busy && prev_busy && inflight) begin
                    inflight = 1'b0;
                    check_output("swap_edge", 32'(selout), 32'd0);
                    check_output("load_latency", 32'(busy_len <= 34), 32'd1);
                    cur_blank = cur_load.blank;
                    cur_slot  = cur_load.slot;
                    cur_glyph = cur_load.glyph;
                end
            end
            prev_busy = busy;
            check_output("selout", 32'(selout), 32'(exp_sel));
            check_output("char_idx", 32'(char_idx), 32'(cur_slot));
            check_output("dotout", 32'(dotout), cur_blank ? 32'd0 : 32'(rom_word(cur_glyph, exp_sel)));
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        mon_en = 1'b1;
        check_output("rst_selout", 32'(selout), 32'd0);
        check_output("rst_dotout", 32'(dotout), 32'd0);
        check_output("rst_char_idx", 32'(char_idx), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_rom_addr", 32'(rom_addr), 32'd0);

        // Empty message: a single blank load, no ROM traffic.
        sb.push_back('{slot: 4'd0, glyph: '0, blank: 1'b1, gap: -1});
        lc0 = load_count;
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check_output("blank_load_count", 32'(load_count - lc0), 32'd1);
        check_output("blank_rom_idle", 32'(rom_addr), 32'd0);

        write_slot(4'd0, 6'd5);
        write_slot(4'd1, 6'd9);
        write_slot(4'd2, 6'd1);
        rst     = 1'b1;
        msg_len = 5'd3;
        run     = 1'b1;
        @(negedge clk);
        sb.push_back('{slot: 4'd0, glyph: 6'd5, blank: 1'b0, gap: -1});
        sb.push_back('{slot: 4'd1, glyph: 6'd9, blank: 1'b0, gap: DWELL - 1});
        sb.push_back('{slot: 4'd2, glyph: 6'd1, blank: 1'b0, gap: DWELL});
        sb.push_back('{slot: 4'd0, glyph: 6'd5, blank: 1'b0, gap: DWELL});
        sb.push_back('{slot: 4'd1, glyph: 6'd9, blank: 1'b0, gap: DWELL + 300});
        sb.push_back('{slot: 4'd2, glyph: 6'd1, blank: 1'b0, gap: DWELL});
        sb.push_back('{slot: 4'd0, glyph: 6'd5, blank: 1'b0, gap: DWELL});
        sb.push_back('{slot: 4'd1, glyph: 6'd7, blank: 1'b0, gap: DWELL});
        sb.push_back('{slot: 4'd2, glyph: 6'd1, blank: 1'b0, gap: DWELL});
        sb.push_back('{slot: 4'd0, glyph: 6'd3, blank: 1'b0, gap: DWELL});
        sb.push_back('{slot: 4'd1, glyph: 6'd7, blank: 1'b0, gap: DWELL});
        rst = 1'b0;
        repeat (4) wait_load_start(400);

        // Freeze the dwell part-way through the slot-0 load for 300 cycles.
        repeat (10) @(negedge clk);
        run = 1'b0;
        repeat (300) @(negedge clk);
        check_output("pause_char_idx", 32'(char_idx), 32'd0);
        check_output("pause_busy", 32'(busy), 32'd0);
        run = 1'b1;

        wait_load_start(400);
        repeat (3) @(negedge clk);
        write_slot(4'd1, 6'd7);

        // Write slot 0 on the very edge its next fetch reads it.
        wait_load_start(400);
        repeat (DWELL - 1) @(negedge clk);
        write_slot(4'd0, 6'd3);

        repeat (4) wait_load_start(400);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_output("abort_dotout", 32'(dotout), 32'd0);
        check_output("abort_selout", 32'(selout), 32'd0);
        check_output("abort_busy", 32'(busy), 32'd0);
        check_output("abort_rom_addr", 32'(rom_addr), 32'd0);
        sb.push_back('{slot: 4'd0, glyph: 6'd3, blank: 1'b0, gap: -1});
        sb.push_back('{slot: 4'd1, glyph: 6'd7, blank: 1'b0, gap: DWELL - 1});
        sb.push_back('{slot: 4'd0, glyph: 6'd3, blank: 1'b0, gap: DWELL});
        rst = 1'b0;

        repeat (2) wait_load_start(400);
        msg_len = 5'd1;
        wait_load_start(400);

        fell = 1'b0;
        for (int i = 0; i < 40 && !fell; i++) begin
            @(negedge clk);
            if (!busy) fell = 1'b1;
        end
        check_output("final_load_done", 32'(fell), 32'd1);
        repeat (4) @(negedge clk);
        check_output("sb_drained", 32'(sb.size()), 32'd0);
        check_output("final_char_idx", 32'(char_idx), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
